// File: rtl/expr_eval_if.sv
// expr_eval_if: character-in / result-out handshake bundle for expr_eval
interface expr_eval_if #(parameter int W = 16);
  logic [7:0]   in;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] result;
  logic         err;
  modport master (output in, in_valid, in_last, input in_ready, out_valid, result, err);
  modport slave  (input in, in_valid, in_last, output in_ready, out_valid, result, err);
endinterface

// File: rtl/expr_eval.sv
// expr_eval: checks digit (op digit)* syntax and evaluates it with * above +
module expr_eval #(parameter int W = 16) (
  input logic        clk,
  input logic        clr_n,
  expr_eval_if.slave bus
);
  typedef enum logic [1:0] {EXP_NUM, EXP_OP, ERR, DONE} state_e;
  state_e       state_q;
  logic [W-1:0] acc_q, prod_q, result_q, d, prod_d;
  logic         pend_q, err_q, out_valid_q;
  logic         is_dig, is_add, is_mul, fire, ok;
  // decode the character and form the term value a digit would produce
  always_comb begin
    is_dig = bus.in >= 8'd48 && bus.in <= 8'd57;
    is_add = bus.in == 8'd43;
    is_mul = bus.in == 8'd42;
    d      = W'(bus.in - 8'd48);
    prod_d = pend_q ? W'(prod_q * d) : d;
    fire   = bus.in_valid && state_q != DONE;
    ok     = state_q == EXP_NUM && is_dig;
  end
  // sequencing FSM; the final beat of an expression loads result/err for the DONE cycle
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q     <= EXP_NUM;
      acc_q       <= '0;
      prod_q      <= '0;
      pend_q      <= 1'b0;
      result_q    <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (state_q == DONE) begin
      state_q     <= EXP_NUM;
      acc_q       <= '0;
      prod_q      <= '0;
      pend_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (fire) begin
      if (ok) begin
        prod_q <= prod_d;
        pend_q <= 1'b0;
      end
      if (state_q == EXP_OP && is_add) acc_q <= acc_q + prod_q;
      if (state_q == EXP_OP && is_mul) pend_q <= 1'b1;
      if (bus.in_last) begin
        state_q     <= DONE;
        out_valid_q <= 1'b1;
        result_q    <= ok ? acc_q + prod_d : '0;
        err_q       <= !ok;
      end else begin
        state_q <= state_q == EXP_NUM ? (is_dig ? EXP_OP : ERR) :
                   state_q == EXP_OP  ? (is_add || is_mul ? EXP_NUM : ERR) : ERR;
      end
    end
  end
  assign bus.in_ready  = state_q != DONE;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_expr_eval.sv
// tb_expr_eval: directed and random expressions checked against a string-level evaluator
module tb_expr_eval;
  typedef byte bq_t[$];
  logic clk = 0, clr_n = 0;
  int checks = 0, errors = 0, pulses = 0, nexp = 0;
  expr_eval_if #(.W(16)) b16();
  expr_eval_if #(.W(8))  b8();
  assign b8.in       = b16.in;
  assign b8.in_valid = b16.in_valid;
  assign b8.in_last  = b16.in_last;
  expr_eval #(.W(16)) dut16 (.clk(clk), .clr_n(clr_n), .bus(b16.slave));
  expr_eval #(.W(8))  dut8  (.clk(clk), .clr_n(clr_n), .bus(b8.slave));
  always #5 clk = ~clk;
  // count every output pulse of the 16-bit instance
  always @(negedge clk) if (b16.out_valid) pulses++;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic bq_t to_q(string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction
  // reference: {err, 16-bit value}; grammar check by position, then sum of products
  function automatic logic [16:0] model(bq_t q);
    logic [15:0] sum, term;
    bit good = q.size() % 2 == 1;
    for (int i = 0; i < q.size(); i++)
      if (i % 2 == 0) good &= q[i] >= "0" && q[i] <= "9";
      else good &= q[i] == "+" || q[i] == "*";
    if (!good) return {1'b1, 16'd0};
    sum = 0;
    term = 16'(q[0] - 8'd48);
    for (int i = 1; i < q.size(); i += 2)
      if (q[i] == "*") term = term * 16'(q[i+1] - 8'd48);
      else begin
        sum = sum + term;
        term = 16'(q[i+1] - 8'd48);
      end
    return {1'b0, sum + term};
  endfunction
  // wait until the presented beat transfers; leaves time at #1 after that edge
  task automatic xfer();
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (b16.in_ready) begin
        @(posedge clk);
        #1;
        return;
      end
    end
    chk("xfer_timeout", 0, 1);
  endtask
  // gap < 0 picks a random 0..2 idle cycles before each beat after the first
  task automatic send(bq_t q, int gap, bit keep, bit term);
    logic [16:0] e;
    for (int i = 0; i < q.size(); i++) begin
      int g = gap < 0 ? int'($urandom_range(0, 2)) : gap;
      if (i > 0 && g > 0) begin
        b16.in_valid = 0;
        repeat (g) @(posedge clk);
        #1;
      end
      b16.in       = q[i];
      b16.in_last  = term && i == q.size() - 1;
      b16.in_valid = 1;
      xfer();
    end
    if (term) begin
      e = model(q);
      nexp++;
      chk("ov16", b16.out_valid, 1);
      chk("ov8", b8.out_valid, 1);
      chk("rdy_done", b16.in_ready, 0);
      chk("res16", b16.result, e[15:0]);
      chk("err16", b16.err, e[16]);
      chk("res8", b8.result, e[7:0]);
      chk("err8", b8.err, e[16]);
    end
    if (!keep) begin
      b16.in_valid = 0;
      b16.in_last  = 0;
    end
    if (term) begin
      @(posedge clk);
      #1;
      chk("ov_drop", b16.out_valid, 0);
      chk("rdy_back", b16.in_ready, 1);
      chk("res_hold", b16.result, e[15:0]);
    end
  endtask
  initial begin
    bq_t q;
    b16.in = 0;
    b16.in_valid = 0;
    b16.in_last = 0;
    repeat (2) @(posedge clk);
    #1;
    clr_n = 1;
    chk("rst_rdy", b16.in_ready, 1);
    chk("rst_ov", b16.out_valid, 0);
    chk("rst_res", b16.result, 0);
    chk("rst_err", b16.err, 0);
    send(to_q("3+4*5"), 0, 0, 1);
    send(to_q("2*3*4"), 3, 0, 1);
    send(to_q("7"), 0, 0, 1);
    send(to_q("3++4"), 0, 0, 1);
    send(to_q("a"), 0, 0, 1);
    send(to_q("5+"), 0, 0, 1);
    send(to_q("12"), 0, 0, 1);
    send(to_q("9*9*9"), 0, 0, 1);
    send(to_q("1+1"), 0, 1, 1);
    send(to_q("2*2"), 0, 0, 1);
    send(to_q("8*"), 0, 0, 0);
    b16.in = "6";
    b16.in_last = 1;
    b16.in_valid = 1;
    clr_n = 0;
    @(posedge clk);
    #1;
    clr_n = 1;
    chk("rst_mid_ov", b16.out_valid, 0);
    chk("rst_mid_rdy", b16.in_ready, 1);
    xfer();
    nexp++;
    chk("rst_mid_ov2", b16.out_valid, 1);
    chk("rst_mid_res", b16.result, 6);
    chk("rst_mid_err", b16.err, 0);
    b16.in_valid = 0;
    b16.in_last = 0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 40; k++) begin
      int len = $urandom_range(1, 7);
      q.delete();
      for (int i = 0; i < len; i++)
        if ($urandom_range(0, 9) == 0) q.push_back(byte'($urandom_range(33, 126)));
        else if (i % 2 == 0) q.push_back(byte'(8'd48 + 8'($urandom_range(0, 9))));
        else q.push_back($urandom_range(0, 1) ? "+" : "*");
      send(q, -1, $urandom_range(0, 1), 1);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("pulses", pulses, nexp);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/expr_eval.md
# expr_eval

Sequencing controller for the operand/operator character datapath. It consumes a byte stream through a valid/ready handshake, one character per beat, and checks the syntax digit (op digit)*. It evaluates the expression with `*` binding tighter than `+` and returns one result per expression, marked by `in_last`. It sits downstream of the character source and upstream of the result consumer, which takes one result-valid pulse per expression.

## Interface
- `W`, 16: width of the accumulator, product and `result`; all arithmetic wraps modulo 2^W.
- `clk`  in  1  clock; all state changes on the rising edge.
- `clr_n`  in  1  synchronous, active-low reset.
- `in`  in  8  ASCII character: `0`–`9` (48–57) is an operand, `+` (43) is add, `*` (42) is multiply; any other code is illegal.
- `in_valid`  in  1  `in` and `in_last` are valid this cycle.
- `in_last`  in  1  this character ends the expression.
- `in_ready`  out  1  the block accepts a character this cycle; a beat transfers when `in_valid & in_ready`.
- `out_valid`  out  1  one-cycle pulse: `result` and `err` are valid.
- `result`  out  W  value of the expression; 0 when `err` is 1.
- `err`  out  1  the expression had a syntax error.

## Operation
- Registers:
  - `acc`: sum of closed terms.
  - `prod`: current term.
  - `pend_mul`: next operand multiplies `prod`.
- FSM states:
  - EXP_NUM, the reset state: an operand is expected.
  - EXP_OP: an operator or the end of the expression is expected.
  - ERR: drain the rest of a bad expression.
  - DONE: the output cycle.
- Define d = `in` − 48, zero-extended to W. Only accepted beats change state.
- In EXP_NUM:
  - digit, `pend_mul`=1: `prod` ← `prod`·d (W bits), `pend_mul` ← 0, go to EXP_OP.
  - digit, `pend_mul`=0: `prod` ← d, go to EXP_OP.
  - operator or illegal code: go to ERR.
- In EXP_OP:
  - `+`: `acc` ← `acc`+`prod`, go to EXP_NUM.
  - `*`: `pend_mul` ← 1, go to EXP_NUM.
  - digit (multi-digit operands are not supported) or illegal code: go to ERR.
- `in_last` handling:
  - on a digit accepted in EXP_NUM: `result` ← `acc`+new `prod`, `err` ← 0, go to DONE.
  - on any other character, or a bad character in any state: `result` ← 0, `err` ← 1, go to DONE.
- In ERR: characters are consumed and ignored until a beat with `in_last`=1, which loads `result` ← 0, `err` ← 1 and goes to DONE.
- In DONE:
  - `out_valid`=1 and `in_ready`=0.
  - Next cycle: go to EXP_NUM and clear `acc`, `prod` and `pend_mul`.
- `result` and `err` hold their values until the next DONE. They are not cleared when leaving DONE.
- `in_ready` = (state ≠ DONE). It is combinational from the state only and never depends on `in_valid`.
- Reset with `clr_n`=0 at a rising edge:
  - state → EXP_NUM; `acc`, `prod`, `pend_mul`, `result`, `err`, `out_valid` → 0.
  - A partially received expression is discarded with no output pulse.
  - Reset has priority over a simultaneous accepted beat.

## Timing
- 1 character per cycle while `in_valid`=1 and the state is not DONE.
- Latency: the `in_last` beat accepted at edge N gives `out_valid`=1 in the cycle after N, for exactly 1 cycle.
- Throughput gap: one dead cycle per expression (DONE). The first character of the next expression can transfer at edge N+2.
- `in_valid`=0 stalls with all registers held; any number of idle cycles is allowed between characters.
- After reset is released: `in_ready`=1, `out_valid`=0, `result`=0, `err`=0.

## Test plan
- W=16, stream `3`,`+`,`4`,`*`,`5`(last) on consecutive cycles:
  - `out_valid` pulses once, on the cycle after `5` transfers.
  - `result`=23, `err`=0.
  - `in_ready`=0 during that cycle only.
- Stream `2*3*4`(last) with `in_valid` dropped for 3 cycles between each beat → `result`=24; `7`(last) alone → `result`=7.
- Syntax errors each give `err`=1, `result`=0, one pulse:
  - `3++4`(last), with error detected at the second `+` and `4` drained.
  - `a`(last).
  - `5+`(last).
  - `12`(last).
- W=8, stream `9*9*9`(last) → `result`=217 (729 mod 256), `err`=0.
- Back-to-back expressions:
  - `1+1`(last) then `2*2`(last), with `in_valid` held at 1.
  - One stall cycle in DONE between them.
  - Results 2 then 4; `acc` is not carried over.
- Reset mid-operation:
  - Stream `8*`, assert `clr_n`=0 for 1 cycle, then stream `6`(last).
  - Required: no pulse for the aborted stream; then `result`=6.
  - A beat presented during the reset cycle is not consumed.
